// File: rtl/line_clearer.sv
// Post-commit line clearer: scans the playfield bottom-to-top, drops full rows,
// compacts the survivors downward and zero-fills the vacated top rows.
module line_clearer #(
  parameter int unsigned width_p  = 16,
  parameter int unsigned height_p = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         start_i,
  output logic                         busy_o,
  input  logic                         mem_ready_i,
  output logic [$clog2(height_p)-1:0]  read_addr_o,
  input  logic [width_p-1:0]           read_data_i,
  output logic [$clog2(height_p)-1:0]  write_addr_o,
  output logic [width_p-1:0]           write_data_o,
  output logic                         v_w_o,
  output logic                         done_o,
  output logic [$clog2(height_p):0]    lines_cleared_o
);

  localparam int unsigned AddrW = $clog2(height_p);
  localparam int unsigned PtrW  = AddrW + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StFill = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [PtrW-1:0] RowBottom = PtrW'(height_p - 1);

  logic [1:0]      state_q, state_d;
  // Pointers carry one extra bit so stepping past row 0 is distinguishable.
  logic [PtrW-1:0] rd_q, rd_d;
  logic [PtrW-1:0] wr_q, wr_d;
  logic [PtrW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] lines_q, lines_d;
  logic            row_full;

  assign row_full        = &read_data_i;
  assign busy_o          = (state_q != StIdle);
  assign lines_cleared_o = lines_q;

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    lines_d      = lines_q;
    read_addr_o  = '0;
    write_addr_o = '0;
    write_data_o = '0;
    v_w_o        = 1'b0;
    done_o       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          rd_d    = RowBottom;
          wr_d    = RowBottom;
          cnt_d   = '0;
          state_d = StScan;
        end
      end

      StScan: begin
        read_addr_o = rd_q[AddrW-1:0];
        if (mem_ready_i) begin
          if (row_full) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            // A surviving row already in place needs no rewrite.
            if (wr_q != rd_q) begin
              v_w_o        = 1'b1;
              write_addr_o = wr_q[AddrW-1:0];
              write_data_o = read_data_i;
            end
            wr_d = wr_q - 1'b1;
          end
          rd_d = rd_q - 1'b1;
          if (rd_q == '0) begin
            if (cnt_d != '0) begin
              state_d = StFill;
            end else begin
              state_d = StDone;
              lines_d = cnt_d;
            end
          end
        end
      end

      StFill: begin
        if (mem_ready_i) begin
          v_w_o        = 1'b1;
          write_addr_o = wr_q[AddrW-1:0];
          if (wr_q == '0) begin
            state_d = StDone;
            lines_d = cnt_q;
          end else begin
            wr_d = wr_q - 1'b1;
          end
        end
      end

      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      rd_q    <= RowBottom;
      wr_q    <= RowBottom;
      cnt_q   <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
    end
  end

endmodule
